poly_bank_dma: RTL

- Parametrised load/unload engine that moves one full polynomial (BN*MA coefficients) between a valid/ready stream and the BN banked dual-port SRAMs of memory_wrapper.
- Replaces hierarchical backdoor preload/dump for NWC/NTT runs.
- Sits beside the NTT core on the SRAM port A side and owns the banks only while busy.
- Two address orders: coefficient-interleaved (coef k -> bank k%BN, addr k/BN) and bank-major (bank 0 addr 0..MA-1, then bank 1, ...).

---
 rtl/poly_dma_pkg.sv | 33 +++
 rtl/dma_skid_fifo.sv | 55 +++++
 rtl/poly_bank_dma.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/poly_dma_pkg.sv
// Shared types and the coefficient-index mapping for the polynomial bank DMA.
package poly_dma_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    UNLOAD = 3'd2,
    DRAIN  = 3'd3,
    FIN    = 3'd4
  } dma_state_e;

  localparam logic MODE_LOAD   = 1'b0;
  localparam logic MODE_UNLOAD = 1'b1;
  localparam logic ORD_INTLV   = 1'b0;
  localparam logic ORD_BANK    = 1'b1;

  // Maps a coefficient index to a physical location packed as
  // (bank << aw) | addr, so bank and address can be sliced out by the caller.
  function automatic logic [31:0] map_index(input logic [31:0] idx, input logic ord,
                                            input int bn_log2, input int aw);
    logic [31:0] bank;
    logic [31:0] addr;
    if (ord == ORD_INTLV) begin
      bank = idx & ((32'd1 << bn_log2) - 32'd1);
      addr = idx >> bn_log2;
    end else begin
      bank = idx >> aw;
      addr = idx & ((32'd1 << aw) - 32'd1);
    end
    return (bank << aw) | addr;
  endfunction

endpackage

// File: rtl/dma_skid_fifo.sv
// Two-entry skid FIFO on the UNLOAD output path; push and pop may coincide at any occupancy.
module dma_skid_fifo #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [D_WIDTH-1:0] din,
  input  logic               pop,
  output logic [D_WIDTH-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [1:0]         count
);

  logic [D_WIDTH-1:0] slot_reg [2];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         count_reg;
  logic               push_ok;
  logic               pop_ok;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  assign count   = count_reg;
  assign dout    = slot_reg[rd_ptr_reg];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage, pointers and occupancy; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_reg[0] <= '0;
      slot_reg[1] <= '0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      count_reg   <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) begin
        slot_reg[wr_ptr_reg] <= din;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop_ok) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/poly_bank_dma.sv
// Load/unload engine moving one polynomial between a stream and BN banked SRAMs.
module poly_bank_dma
  import poly_dma_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int BN      = 16,
  parameter int MA      = 512,
  parameter int AW      = $clog2(MA),
  parameter int IW      = $clog2(BN*MA)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  order,
  input  logic                  abort,
  input  logic [D_WIDTH-1:0]    modulus,
  output logic                  busy,
  output logic                  done,
  output logic                  range_err,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [D_WIDTH-1:0]    s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [D_WIDTH-1:0]    m_data,
  output logic [BN-1:0]         mem_cen,
  output logic                  mem_wen,
  output logic [AW-1:0]         mem_addr,
  output logic [D_WIDTH-1:0]    mem_wdata,
  input  logic [BN*D_WIDTH-1:0] mem_rdata
);

  localparam int              BL       = $clog2(BN);
  localparam logic [IW-1:0]   LAST_IDX = IW'(BN*MA-1);

  dma_state_e         state_reg;
  logic [IW-1:0]      idx_reg;
  logic               order_reg;
  logic               range_err_reg;
  logic               inflight_reg;
  logic [BL-1:0]      rd_bank_reg;
  logic [BN-1:0]      wr_cen_reg;
  logic               wr_wen_reg;
  logic [AW-1:0]      wr_addr_reg;
  logic [D_WIDTH-1:0] wr_data_reg;

  logic [31:0]        loc;
  logic [BL-1:0]      cur_bank;
  logic [AW-1:0]      cur_addr;
  logic [BN-1:0]      cur_onehot;
  logic               unused_loc_hi;
  logic               unused_fifo_full;
  logic [1:0]         fifo_count;
  logic               fifo_empty;
  logic [2:0]         occ;
  logic               pop;
  logic               rd_fire;
  logic               load_beat;
  logic [D_WIDTH-1:0] rd_word;

  assign loc           = map_index(32'(idx_reg), order_reg, BL, AW);
  assign cur_bank      = loc[AW +: BL];
  assign cur_addr      = loc[AW-1:0];
  assign unused_loc_hi = ^loc[31:IW];
  assign cur_onehot    = BN'(1) << cur_bank;

  assign busy      = (state_reg == LOAD) || (state_reg == UNLOAD) || (state_reg == DRAIN);
  assign done      = (state_reg == FIN);
  assign s_ready   = (state_reg == LOAD);
  assign range_err = range_err_reg;
  assign m_valid   = !fifo_empty;

  // An aborted cycle never writes, so the beat presented alongside abort is dropped.
  assign load_beat = (state_reg == LOAD) && s_valid && !abort;

  // Reads are issued only when the FIFO can absorb the result even if this
  // cycle's pop is counted, which keeps one word per cycle flowing with m_ready high.
  assign pop     = m_valid && m_ready;
  assign occ     = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
  assign rd_fire = (state_reg == UNLOAD) && !abort && (occ < 3'd2);

  assign rd_word = mem_rdata[rd_bank_reg*D_WIDTH +: D_WIDTH];

  // Write strobes are registered; read strobes go out in the issuing cycle.
  assign mem_cen   = wr_cen_reg | (rd_fire ? cur_onehot : '0);
  assign mem_wen   = wr_wen_reg;
  assign mem_addr  = rd_fire ? cur_addr : wr_addr_reg;
  assign mem_wdata = wr_data_reg;

  dma_skid_fifo #(.D_WIDTH(D_WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort && busy),
    .push  (inflight_reg),
    .din   (rd_word),
    .pop   (pop),
    .dout  (m_data),
    .full  (unused_fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Transfer sequencing, index walk, write strobe registers and read tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      order_reg     <= ORD_INTLV;
      range_err_reg <= 1'b0;
      inflight_reg  <= 1'b0;
      rd_bank_reg   <= '0;
      wr_cen_reg    <= '0;
      wr_wen_reg    <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      wr_cen_reg   <= '0;
      wr_wen_reg   <= 1'b0;
      inflight_reg <= rd_fire;
      if (rd_fire) begin
        rd_bank_reg <= cur_bank;
      end
      if (load_beat) begin
        wr_cen_reg  <= cur_onehot;
        wr_wen_reg  <= 1'b1;
        wr_addr_reg <= cur_addr;
        wr_data_reg <= s_data;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= (mode == MODE_UNLOAD) ? UNLOAD : LOAD;
            idx_reg       <= '0;
            order_reg     <= order;
            range_err_reg <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (s_valid) begin
            if (s_data >= modulus) begin
              range_err_reg <= 1'b1;
            end
            idx_reg <= idx_reg + 1'b1;
            if (idx_reg == LAST_IDX) begin
              state_reg <= DRAIN;
            end
          end
        end
        UNLOAD: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (rd_fire) begin
            idx_reg <= idx_reg + 1'b1;
            if (idx_reg == LAST_IDX) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (fifo_empty && !inflight_reg) begin
            state_reg <= FIN;
          end
        end
        FIN:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
